// File: rtl/mcu_pkg.sv
// Shared definitions for the memory arbiter.
//   arb_state_t    : arbiter FSM state encoding
//   OWN_NONE/CPU/DBG : values driven on the owner output
//   BURST_W        : width of the consecutive-grant counter
//   other_owner()  : the requester that is not the given owner
package mcu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CPU_ACC  = 3'd1,
        ST_CPU_RESP = 3'd2,
        ST_DBG_ACC  = 3'd3,
        ST_DBG_RESP = 3'd4
    } arb_state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_DBG  = 2'b10;

    localparam int BURST_W = 4;

    function automatic logic [1:0] other_owner(input logic [1:0] own);
        return (own == OWN_CPU) ? OWN_DBG : OWN_CPU;
    endfunction

endpackage

// File: rtl/arb_select.sv
// Combinational winner selection between the CPU and debug requesters.
// Build option: MEM_ARB_RR_EN defined -> ties go to the requester not
// served last; undefined -> ties go to the CPU.
// Ports:
//   cpu_req_i, dbg_req_i : pending requests
//   last_owner_i         : requester granted most recently (OWN_CPU/OWN_DBG)
//   burst_cnt_i          : consecutive grants to last_owner_i
//   grant_o              : OWN_NONE / OWN_CPU / OWN_DBG
module arb_select
    import mcu_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic               cpu_req_i,
    input  logic               dbg_req_i,
    input  logic [1:0]         last_owner_i,
    input  logic [BURST_W-1:0] burst_cnt_i,
    output logic [1:0]         grant_o
);

    always_comb begin
        grant_o = OWN_NONE;
        if (cpu_req_i && dbg_req_i) begin
            // Burst limit overrides the tie rule so neither side starves.
            if (burst_cnt_i == BURST_W'(MAX_BURST)) begin
                grant_o = other_owner(last_owner_i);
            end else begin
`ifdef MEM_ARB_RR_EN
                grant_o = other_owner(last_owner_i);
`else
                grant_o = OWN_CPU;
`endif
            end
        end else if (cpu_req_i) begin
            grant_o = OWN_CPU;
        end else if (dbg_req_i) begin
            grant_o = OWN_DBG;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU / debug loader) arbiter in front of a single-port
// synchronous-read memory. Each access takes two cycles: address phase
// (ACC) then response phase (RESP, ack pulse). Back-to-back accesses
// go RESP -> ACC without an idle cycle.
// Build option: MEM_ARB_RR_EN selects round-robin tie breaking (see
// arb_select); default is fixed CPU priority.
// Ports:
//   clk, reset                  : clock, async active-high reset
//   cpu_* / dbg_*               : requester ports (req held until ack)
//   mem_addr/mem_wdata/mem_we   : memory command
//   mem_rdata                   : memory data, one cycle after address
//   owner                       : 00 none, 01 CPU, 10 debug
//
// state        | meaning
// ST_IDLE      | no access, memory bus parked at 0
// ST_CPU_ACC   | CPU address/data on memory bus
// ST_CPU_RESP  | CPU ack, read data returned, next grant decided
// ST_DBG_ACC   | debug address/data on memory bus
// ST_DBG_RESP  | debug ack, read data returned, next grant decided
module mem_arbiter
    import mcu_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);

    arb_state_t         state_q;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [1:0]         last_q;
    logic               acc_we_q;
    logic [1:0]         owner_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;
    logic               mem_we_q;
    logic               cpu_ack_q;
    logic               dbg_ack_q;

    logic [1:0]         grant;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    arb_select #(.MAX_BURST(MAX_BURST)) u_select (
        .cpu_req_i    (cpu_req),
        .dbg_req_i    (dbg_req),
        .last_owner_i (last_q),
        .burst_cnt_i  (burst_q),
        .grant_o      (grant)
    );

    assign sel_we    = (grant == OWN_DBG) ? dbg_we    : cpu_we;
    assign sel_addr  = (grant == OWN_DBG) ? dbg_addr  : cpu_addr;
    assign sel_wdata = (grant == OWN_DBG) ? dbg_wdata : cpu_wdata;

    // Count saturates at MAX_BURST so the limit compare stays an equality.
    always_comb begin
        burst_d = BURST_W'(1);
        if (grant == last_q) begin
            burst_d = (burst_q == BURST_W'(MAX_BURST)) ? burst_q : burst_q + BURST_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            burst_q     <= '0;
            last_q      <= OWN_DBG;
            acc_we_q    <= 1'b0;
            owner_q     <= OWN_NONE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
        end else begin
            mem_we_q  <= 1'b0;
            cpu_ack_q <= 1'b0;
            dbg_ack_q <= 1'b0;
            case (state_q)
                ST_CPU_ACC: begin
                    state_q   <= ST_CPU_RESP;
                    cpu_ack_q <= 1'b1;
                end
                ST_DBG_ACC: begin
                    state_q   <= ST_DBG_RESP;
                    dbg_ack_q <= 1'b1;
                end
                ST_IDLE, ST_CPU_RESP, ST_DBG_RESP: begin
                    if (grant == OWN_NONE) begin
                        state_q     <= ST_IDLE;
                        owner_q     <= OWN_NONE;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        acc_we_q    <= 1'b0;
                        burst_q     <= '0;
                    end else begin
                        state_q     <= (grant == OWN_DBG) ? ST_DBG_ACC : ST_CPU_ACC;
                        owner_q     <= grant;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                        mem_we_q    <= sel_we;
                        acc_we_q    <= sel_we;
                        burst_q     <= burst_d;
                        last_q      <= grant;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    owner_q     <= OWN_NONE;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    acc_we_q    <= 1'b0;
                    burst_q     <= '0;
                end
            endcase
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign dbg_ack   = dbg_ack_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign owner     = owner_q;
    // Read data arrives from memory during RESP, so it is passed through.
    assign cpu_rdata = (cpu_ack_q && !acc_we_q) ? mem_rdata : '0;
    assign dbg_rdata = (dbg_ack_q && !acc_we_q) ? mem_rdata : '0;

endmodule
